// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ISA constants, ALU select codes and control bundle type
package cpu_pkg;

  localparam int ALU_SEL_W = 4;
  localparam int REG_IDX_W = 3;
  localparam int OPCODE_W  = 5;

  // inst[7]=1 marks the ALU instruction class; inst[6:3] is then the ALU select
  localparam int ALU_CLASS_BIT = 7;

  localparam logic [OPCODE_W-1:0] OP_NOP         = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_MOV_TO_R0   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_MOV_FROM_R0 = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDC         = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_LDA         = 5'b00100;

  localparam logic [REG_IDX_W-1:0] REG_R0 = 3'b000;

  // ALU select codes shared with the ALU
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_PASS = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_NOT  = 4'h6,
    ALU_SHL  = 4'h7,
    ALU_SHR  = 4'h8,
    ALU_ROL  = 4'h9,
    ALU_ROR  = 4'hA,
    ALU_INC  = 4'hB,
    ALU_DEC  = 4'hC,
    ALU_ADC  = 4'hD,
    ALU_SBC  = 4'hE,
    ALU_CMP  = 4'hF
  } aluOp_e;

  // Full set of datapath strobes produced per instruction
  typedef struct packed {
    logic [ALU_SEL_W-1:0] aluSel;
    logic [REG_IDX_W-1:0] regInSel;
    logic [REG_IDX_W-1:0] regOutSel;
    logic                 regInEn;
    logic                 regOutEn;
    logic                 genConst;
    logic                 loadAddr;
  } ctrlBundle_t;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational instruction byte to control strobe decode
module control_decode
  import cpu_pkg::*;
(
  input  logic [7:0]  inst,
  output ctrlBundle_t ctrlNext
);

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_IDX_W-1:0] regField;

  assign opcode   = inst[7:3];
  assign regField = inst[2:0];

  // Decode; anything unlisted (NOP, reserved opcodes) stays all-zero so unused selects read 000
  always_comb begin
    ctrlNext = '0;
    if (inst[ALU_CLASS_BIT]) begin
      ctrlNext.aluSel    = inst[6:3];
      ctrlNext.regOutSel = regField;
      ctrlNext.regOutEn  = 1'b1;
      ctrlNext.regInSel  = REG_R0;
      ctrlNext.regInEn   = 1'b1;
    end else begin
      case (opcode)
        OP_MOV_TO_R0: begin
          ctrlNext.regOutSel = regField;
          ctrlNext.regOutEn  = 1'b1;
          ctrlNext.regInSel  = REG_R0;
          ctrlNext.regInEn   = 1'b1;
          ctrlNext.aluSel    = ALU_PASS;
        end
        OP_MOV_FROM_R0: begin
          ctrlNext.regOutSel = REG_R0;
          ctrlNext.regOutEn  = 1'b1;
          ctrlNext.regInSel  = regField;
          ctrlNext.regInEn   = 1'b1;
        end
        OP_LDC: begin
          ctrlNext.genConst = 1'b1;
          ctrlNext.regInSel = regField;
          ctrlNext.regInEn  = 1'b1;
        end
        OP_LDA: begin
          ctrlNext.regOutSel = regField;
          ctrlNext.regOutEn  = 1'b1;
          ctrlNext.loadAddr  = 1'b1;
        end
        default: ctrlNext = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - instruction decoder with registered control outputs
module control_unit
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           inst,
  output logic [ALU_SEL_W-1:0] aluSel,
  output logic [REG_IDX_W-1:0] regInSel,
  output logic [REG_IDX_W-1:0] regOutSel,
  output logic                 regInEn,
  output logic                 regOutEn,
  output logic                 genConst,
  output logic                 loadAddr
);

  ctrlBundle_t ctrlNext;
  ctrlBundle_t ctrlQ;

  control_decode uDecode (
    .inst     (inst),
    .ctrlNext (ctrlNext)
  );

  // Output register; reset wins over decode so every strobe is quiet while rst is high
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlQ <= '0;
    end else begin
      ctrlQ <= ctrlNext;
    end
  end

  assign aluSel    = ctrlQ.aluSel;
  assign regInSel  = ctrlQ.regInSel;
  assign regOutSel = ctrlQ.regOutSel;
  assign regInEn   = ctrlQ.regInEn;
  assign regOutEn  = ctrlQ.regOutEn;
  assign genConst  = ctrlQ.genConst;
  assign loadAddr  = ctrlQ.loadAddr;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with reference model
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] inst;
  logic [3:0] aluSel;
  logic [2:0] regInSel;
  logic [2:0] regOutSel;
  logic       regInEn;
  logic       regOutEn;
  logic       genConst;
  logic       loadAddr;

  typedef struct {
    logic [13:0] vec;
    string       name;
    logic [7:0]  inst;
    bit          rst;
  } expItem_t;

  expItem_t expQ[$];
  int       checks = 0;
  int       passes = 0;
  bit       stimDone = 0;
  logic [13:0] lastExp = '0;

  control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .aluSel    (aluSel),
    .regInSel  (regInSel),
    .regOutSel (regOutSel),
    .regInEn   (regInEn),
    .regOutEn  (regOutEn),
    .genConst  (genConst),
    .loadAddr  (loadAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] actualVec();
    return {aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst, loadAddr};
  endfunction

  // Reference: opcode class by value range, register field by modulo
  function automatic logic [13:0] model(bit r, logic [7:0] i);
    int v, op, rr;
    int a, inSel, outSel, inEn, outEn, gc, la;
    v = i; op = v / 8; rr = v % 8;
    a = 0; inSel = 0; outSel = 0; inEn = 0; outEn = 0; gc = 0; la = 0;
    if (!r) begin
      if (v >= 128) begin
        a = op - 16; outSel = rr; outEn = 1; inEn = 1;
      end else if (op == 1) begin
        outSel = rr; outEn = 1; inEn = 1;
      end else if (op == 2) begin
        inSel = rr; outEn = 1; inEn = 1;
      end else if (op == 3) begin
        gc = 1; inSel = rr; inEn = 1;
      end else if (op == 4) begin
        outSel = rr; outEn = 1; la = 1;
      end
    end
    return {a[3:0], inSel[2:0], outSel[2:0], inEn[0], outEn[0], gc[0], la[0]};
  endfunction

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(bit r, logic [7:0] i, string name);
    expItem_t e;
    @(negedge clk);
    rst = r;
    inst = i;
    e.vec = model(r, i);
    e.name = name;
    e.inst = i;
    e.rst = r;
    expQ.push_back(e);
  endtask

  // Monitor: compare after each edge against the oldest pending expectation
  initial begin
    expItem_t e;
    logic [13:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act = actualVec();
        check($sformatf("%s inst=%h rst=%0d", e.name, e.inst, e.rst), act, e.vec);
        lastExp = e.vec;
        checks++;
        if (!(genConst && regOutEn) && !(genConst && loadAddr) &&
            (regInEn || regInSel == 3'b000) && (regOutEn || regOutSel == 3'b000))
          passes++;
        else
          $display("FAIL invariant inst=%h: got %h", e.inst, act);
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1;
    inst = 8'hFF;
    step(1'b1, 8'hFF, "reset");
    step(1'b1, 8'hFF, "reset_hold");
    step(1'b1, 8'h0B, "reset_hold2");
    step(1'b0, 8'h00, "nop00");
    step(1'b0, 8'h07, "nop07");
    step(1'b0, 8'h28, "reserved28");
    step(1'b0, 8'h78, "reserved78");
    step(1'b0, 8'b00001_011, "mov_to_r0");
    #2;
    check("latency_hold", actualVec(), 14'h0);
    step(1'b0, 8'b00010_101, "mov_from_r0");
    step(1'b0, 8'b00011_010, "ldc");
    step(1'b0, 8'b00100_110, "lda");
    step(1'b0, 8'b1_0110_100, "alu6");
    for (int k = 0; k < 16; k++) begin
      logic [7:0] v;
      v = 8'h80 | 8'(k << 3) | 8'($urandom_range(0, 7));
      step(1'b0, v, "alu_sweep");
    end
    step(1'b0, 8'b00001_011, "mov_before_rst");
    step(1'b1, 8'b00001_011, "mid_rst");
    step(1'b0, 8'b00001_011, "after_rst");
    step(1'b1, 8'hFF, "mid_rst_ff");
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 15) == 0), 8'($urandom), "random");
    end
    cyc = 0;
    while (expQ.size() > 0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
